octal_phase_tracker: RTL
========================

// Module: octal_phase_tracker
// PURPOSE
//  Downstream consumer of the CD4022-style octal one-hot counter. Samples its 8-bit
//  one-hot phase bus and carry, encodes to binary, counts completed 8-phase cycles
//  into a wide total, flags illegal sequences, and pulses on a programmable terminal
//  count. Runs in the same CLOCK domain as the counter; EN is driven by !CLOCK_INHIBIT.
// PARAMETERS
//  CW          8    width of completed-cycle counter CYCLES
//  TC_VALUE    100  TOTAL value that fires TC_PULSE (must be < 2**(CW+3))
//  CHECK_CARRY 0    1 = flag CARRY_IN inconsistent with phase as a fault
// PORTS
//  CLOCK      in   1     system clock, rising edge
//  RESET      in   1     synchronous, active-high
//  EN         in   1     sample enable; 0 = freeze all state
//  PHASE_IN   in   8     one-hot phase from counter (bit n = phase n)
//  CARRY_IN   in   1     counter carry; high for phases 0..3, low for 4..7
//  CLEAR_ERR  in   1     leave FAULT, re-enter SYNC
//  PHASE_BIN  out  3     binary phase of last legal sample
//  CYCLES     out  CW    completed 7->0 wraps, modulo 2**CW
//  TOTAL      out  CW+3  {CYCLES, PHASE_BIN}
//  VALID      out  1     1 only in TRACK
//  TC_PULSE   out  1     one-cycle pulse when TOTAL becomes TC_VALUE
//  ERROR      out  1     sticky fault flag (1 in FAULT)
//  ERR_CODE   out  2     01 not one-hot, 10 phase skip, 11 carry mismatch, 00 none
//  STATE      out  2     00 SYNC, 01 TRACK, 10 FAULT
// BEHAVIOUR
//  - Reset: all outputs 0, STATE=SYNC. RESET overrides EN, CLEAR_ERR, everything.
//  - All outputs registered; sample at edge k is reflected after edge k (latency 1).
//  - EN=0: no state/output change, no fault checks, TC_PULSE forced 0.
//  - SYNC: ignore anything except PHASE_IN==8'h01 -> TRACK, PHASE_BIN=0;
//    CYCLES unchanged (0 after reset). Illegal patterns in SYNC raise no error.
//  - TRACK, per enabled sample, checks in priority order:
//    1) PHASE_IN not exactly one bit set (incl. 0) -> FAULT, ERR_CODE=01
//    2) new phase != PHASE_BIN and != PHASE_BIN+1 mod 8 -> FAULT, ERR_CODE=10
//    3) CHECK_CARRY=1 and CARRY_IN != (new phase<=3) -> FAULT, ERR_CODE=11
//    else legal: hold (same phase) leaves all unchanged; advance updates PHASE_BIN;
//    advance 7->0 increments CYCLES (wraps 2**CW-1 -> 0, no flag).
//  - FAULT: ERROR=1, VALID=0, PHASE_BIN/CYCLES/TOTAL frozen at last legal value,
//    first ERR_CODE latched (later faults do not overwrite).
//    CLEAR_ERR=1 -> SYNC, ERROR=0, ERR_CODE=00, counts kept.
//  - CLEAR_ERR outside FAULT has no effect.
//  - TC_PULSE=1 for exactly the cycle after TOTAL changes to TC_VALUE; re-fires
//    after a CYCLES wrap brings TOTAL back to TC_VALUE; never fires on a hold.
//  - Reset mid-FAULT or mid-TRACK: immediate return to reset values next edge.
// TESTING
//  1 Reset, EN=1, drive 01,02,04..80,01 per cycle -> PHASE_BIN 0..7,0; CYCLES=1, TOTAL=8, VALID=1
//  2 TC_VALUE=10: run phases from 0 -> TC_PULSE high only the cycle TOTAL=10; hold phase 2 -> no repeat
//  3 In TRACK at phase 3 drive 8'h18 -> STATE=FAULT, ERROR=1, ERR_CODE=01, TOTAL frozen
//  4 At phase 2 drive 8'h20 (skip) -> ERR_CODE=10; then CLEAR_ERR=1 -> SYNC, ERROR=0; 8'h01 -> TRACK
//  5 CHECK_CARRY=1, phase 5 with CARRY_IN=1 -> ERR_CODE=11; CHECK_CARRY=0 same stimulus -> no fault
//  6 EN=0 with garbage PHASE_IN for 5 cycles -> outputs unchanged; RESET mid-count -> all 0, SYNC

Source files
------------

// File: rtl/octal_phase_tracker.sv
// Tracks the one-hot phase bus of an octal counter: encodes the phase, counts completed
// 8-phase cycles, latches the first illegal-sequence fault and pulses on a terminal count.
module octal_phase_tracker #(
    parameter int CW          = 8,
    parameter int TC_VALUE    = 100,
    parameter bit CHECK_CARRY = 1'b0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          EN,
    input  logic [7:0]    PHASE_IN,
    input  logic          CARRY_IN,
    input  logic          CLEAR_ERR,
    output logic [2:0]    PHASE_BIN,
    output logic [CW-1:0] CYCLES,
    output logic [CW+2:0] TOTAL,
    output logic          VALID,
    output logic          TC_PULSE,
    output logic          ERROR,
    output logic [1:0]    ERR_CODE,
    output logic [1:0]    STATE
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [CW+2:0] TC_L = (CW+3)'(TC_VALUE);

    state_t        state_q, state_d;
    logic [2:0]    phase_bin_q, phase_bin_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          tc_pulse_q, tc_pulse_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic          one_hot;
    logic [2:0]    new_phase;
    logic [2:0]    next_phase;
    logic          carry_ok;
    logic [CW+2:0] total_q, total_d;

    always_comb begin
        one_hot   = (PHASE_IN != 8'd0) && ((PHASE_IN & (PHASE_IN - 8'd1)) == 8'd0);
        new_phase = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PHASE_IN[i]) new_phase = 3'(i);
        end
        next_phase = phase_bin_q + 3'd1;
        // The counter's carry is high for the lower half of the cycle (phases 0..3).
        carry_ok   = (CARRY_IN == ~new_phase[2]);
    end

    always_comb begin
        state_d     = state_q;
        phase_bin_d = phase_bin_q;
        cycles_d    = cycles_q;
        err_code_d  = err_code_q;
        if (EN) begin
            case (state_q)
                ST_SYNC: begin
                    if (PHASE_IN == 8'h01) begin
                        state_d     = ST_TRACK;
                        phase_bin_d = 3'd0;
                    end
                end
                ST_TRACK: begin
                    if (!one_hot) begin
                        state_d    = ST_FAULT;
                        err_code_d = 2'b01;
                    end else if (new_phase != phase_bin_q && new_phase != next_phase) begin
                        state_d    = ST_FAULT;
                        err_code_d = 2'b10;
                    end else if (CHECK_CARRY && !carry_ok) begin
                        state_d    = ST_FAULT;
                        err_code_d = 2'b11;
                    end else if (new_phase == next_phase) begin
                        phase_bin_d = new_phase;
                        if (phase_bin_q == 3'd7) cycles_d = cycles_q + CW'(1);
                    end
                end
                ST_FAULT: begin
                    if (CLEAR_ERR) begin
                        state_d    = ST_SYNC;
                        err_code_d = 2'b00;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
        total_q    = {cycles_q, phase_bin_q};
        total_d    = {cycles_d, phase_bin_d};
        // Pulse only on a change into the terminal value, so holds never re-fire it.
        tc_pulse_d = EN && (total_d != total_q) && (total_d == TC_L);
        valid_d    = (state_d == ST_TRACK);
        error_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_SYNC;
            phase_bin_q <= 3'd0;
            cycles_q    <= '0;
            err_code_q  <= 2'b00;
            tc_pulse_q  <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_bin_q <= phase_bin_d;
            cycles_q    <= cycles_d;
            err_code_q  <= err_code_d;
            tc_pulse_q  <= tc_pulse_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
        end
    end

    assign PHASE_BIN = phase_bin_q;
    assign CYCLES    = cycles_q;
    assign TOTAL     = total_q;
    assign VALID     = valid_q;
    assign TC_PULSE  = tc_pulse_q;
    assign ERROR     = error_q;
    assign ERR_CODE  = err_code_q;
    assign STATE     = state_q;

endmodule
